round_robin_arbiter: RTL and testbench



---
 rtl/round_robin_arbiter.sv | 124 ++++++++++++
 tb/tb_round_robin_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter.sv
// Registered round-robin arbiter: one-hot grant held until accepted, priority
// then rotates past the winner ("round_robin") or stays at index 0 ("fixed").
module round_robin_arbiter #(
    parameter int    WIDTH   = 8,
    parameter string VARIANT = "fast",
    parameter string MODE    = "round_robin",
    localparam int   IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] requests,
    output logic [WIDTH-1:0] grant,
    output logic [IW-1:0]    grant_index,
    output logic             grant_valid,
    input  logic             grant_ready
);

    logic [WIDTH-1:0] grant_reg;
    logic [IW-1:0]    grant_index_reg;
    logic             grant_valid_reg;
    logic [IW-1:0]    ptr_reg;

    logic [IW-1:0]    ptr_next;
    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] pick_masked;
    logic [WIDTH-1:0] pick_all;
    logic [WIDTH-1:0] grant_next;
    logic             arb_en;

    function automatic logic [WIDTH-1:0] lowest_linear(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] encode(input logic [WIDTH-1:0] oh);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (oh[i]) r = r | IW'(i);
        end
        return r;
    endfunction

    generate
        if (VARIANT == "fast") begin : g_fast
            // Two's-complement trick isolates the lowest set bit in one carry chain.
            assign pick_masked = masked & (~masked + WIDTH'(1));
            assign pick_all    = requests & (~requests + WIDTH'(1));
        end else if (VARIANT == "small") begin : g_small
            assign pick_masked = lowest_linear(masked);
            assign pick_all    = lowest_linear(requests);
        end else begin : g_bad_variant
            $error("round_robin_arbiter: VARIANT must be \"small\" or \"fast\"");
            assign pick_masked = '0;
            assign pick_all    = '0;
        end

        if (MODE != "round_robin" && MODE != "fixed") begin : g_bad_mode
            $error("round_robin_arbiter: MODE must be \"round_robin\" or \"fixed\"");
        end

        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign masked[gi] = requests[gi] & (IW'(gi) >= ptr_next);
        end
    endgenerate

    assign arb_en = !grant_valid_reg || grant_ready;

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_valid_reg && grant_ready) begin
            if (MODE == "fixed" || grant_index_reg == IW'(WIDTH - 1))
                ptr_next = '0;
            else
                ptr_next = grant_index_reg + IW'(1);
        end
    end

    assign grant_next = (|masked) ? pick_masked : pick_all;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_reg       <= '0;
            grant_index_reg <= '0;
            grant_valid_reg <= 1'b0;
            ptr_reg         <= '0;
        end else if (arb_en) begin
            grant_reg       <= grant_next;
            grant_index_reg <= encode(grant_next);
            grant_valid_reg <= |requests;
            ptr_reg         <= ptr_next;
        end
    end

    assign grant       = grant_reg;
    assign grant_index = grant_index_reg;
    assign grant_valid = grant_valid_reg;

    a_onehot: assert property (@(posedge clock) disable iff (reset)
        $onehot0(grant_reg));
    a_valid_iff_grant: assert property (@(posedge clock) disable iff (reset)
        ((grant_reg != '0) == grant_valid_reg));
    a_index_matches: assert property (@(posedge clock) disable iff (reset)
        (!grant_valid_reg || grant_reg[grant_index_reg]));

    generate
        if (MODE == "round_robin" && WIDTH > 1) begin : g_fair
            // A winner must not win again straight away while someone else is waiting.
            a_no_repeat: assert property (@(posedge clock) disable iff (reset)
                (grant_valid_reg && grant_ready && |(requests & ~grant_reg))
                |=> (grant_reg != $past(grant_reg)));
        end
    endgenerate

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench: round-robin rotation, hold, wrap, idle, async reset, fixed mode, WIDTH=1.
module tb_round_robin_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] requests;
    logic [3:0] grant;
    logic [1:0] grant_index;
    logic       grant_valid;
    logic       grant_ready;

    logic [3:0] f_requests;
    logic [3:0] f_grant;
    logic [1:0] f_grant_index;
    logic       f_grant_valid;
    logic       f_grant_ready;

    logic [0:0] w_requests;
    logic [0:0] w_grant;
    logic [0:0] w_grant_index;
    logic       w_grant_valid;
    logic       w_grant_ready;

    int total = 0;
    int bad   = 0;

    round_robin_arbiter #(.WIDTH(4), .VARIANT("fast"), .MODE("round_robin")) dut (
        .clock(clock), .reset(reset), .requests(requests), .grant(grant),
        .grant_index(grant_index), .grant_valid(grant_valid), .grant_ready(grant_ready)
    );

    round_robin_arbiter #(.WIDTH(4), .VARIANT("small"), .MODE("fixed")) dut_fixed (
        .clock(clock), .reset(reset), .requests(f_requests), .grant(f_grant),
        .grant_index(f_grant_index), .grant_valid(f_grant_valid), .grant_ready(f_grant_ready)
    );

    round_robin_arbiter #(.WIDTH(1), .VARIANT("fast"), .MODE("round_robin")) dut_w1 (
        .clock(clock), .reset(reset), .requests(w_requests), .grant(w_grant),
        .grant_index(w_grant_index), .grant_valid(w_grant_valid), .grant_ready(w_grant_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_rr(input string tag, input logic [3:0] eg, input logic [1:0] ei, input logic ev);
        total++;
        assert (grant === eg) else begin
            bad++;
            $error("FAIL %s grant got=%b exp=%b", tag, grant, eg);
        end
        total++;
        assert (grant_index === ei) else begin
            bad++;
            $error("FAIL %s grant_index got=%0d exp=%0d", tag, grant_index, ei);
        end
        total++;
        assert (grant_valid === ev) else begin
            bad++;
            $error("FAIL %s grant_valid got=%b exp=%b", tag, grant_valid, ev);
        end
        $display("%s: grant=%b idx=%0d valid=%b", tag, grant, grant_index, grant_valid);
    endtask

    task automatic check_fixed(input string tag, input logic [3:0] eg, input logic [1:0] ei, input logic ev);
        total++;
        assert (f_grant === eg && f_grant_index === ei && f_grant_valid === ev) else begin
            bad++;
            $error("FAIL %s got grant=%b idx=%0d valid=%b exp grant=%b idx=%0d valid=%b",
                   tag, f_grant, f_grant_index, f_grant_valid, eg, ei, ev);
        end
        $display("%s: grant=%b idx=%0d valid=%b", tag, f_grant, f_grant_index, f_grant_valid);
    endtask

    task automatic check_w1(input string tag, input logic eg, input logic ev);
        total++;
        assert (w_grant === eg && w_grant_index === 1'b0 && w_grant_valid === ev) else begin
            bad++;
            $error("FAIL %s got grant=%b idx=%0d valid=%b exp grant=%b idx=0 valid=%b",
                   tag, w_grant, w_grant_index, w_grant_valid, eg, ev);
        end
        $display("%s: grant=%b idx=%0d valid=%b", tag, w_grant, w_grant_index, w_grant_valid);
    endtask

    initial begin
        reset         = 1'b1;
        requests      = 4'b0000;
        grant_ready   = 1'b0;
        f_requests    = 4'b0000;
        f_grant_ready = 1'b0;
        w_requests    = 1'b0;
        w_grant_ready = 1'b0;

        #2;
        check_rr("reset", 4'b0000, 2'd0, 1'b0);
        tick();
        reset = 1'b0;

        // Full rotation with everyone requesting
        requests    = 4'b1111;
        grant_ready = 1'b1;
        tick(); check_rr("rot0", 4'b0001, 2'd0, 1'b1);
        tick(); check_rr("rot1", 4'b0010, 2'd1, 1'b1);
        tick(); check_rr("rot2", 4'b0100, 2'd2, 1'b1);
        tick(); check_rr("rot3", 4'b1000, 2'd3, 1'b1);
        tick(); check_rr("rot4", 4'b0001, 2'd0, 1'b1);

        // Hold: grant 0010 must survive ready=0 and request changes
        requests = 4'b0110;
        tick(); check_rr("hold_start", 4'b0010, 2'd1, 1'b1);
        grant_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(); check_rr($sformatf("hold%0d", i), 4'b0010, 2'd1, 1'b1);
            requests = 4'b1000;
        end
        grant_ready = 1'b1;
        tick(); check_rr("hold_release", 4'b1000, 2'd3, 1'b1);

        // Wrap: grant index 2 so the pointer becomes 3, then only low bits request
        requests = 4'b0100;
        tick(); check_rr("wrap_prep", 4'b0100, 2'd2, 1'b1);
        requests = 4'b0011;
        tick(); check_rr("wrap0", 4'b0001, 2'd0, 1'b1);
        tick(); check_rr("wrap1", 4'b0010, 2'd1, 1'b1);

        // Requests vanish; ready pulses while idle change nothing (pointer stays 2)
        requests = 4'b0000;
        tick(); check_rr("idle0", 4'b0000, 2'd0, 1'b0);
        grant_ready = 1'b0;
        tick(); check_rr("idle1", 4'b0000, 2'd0, 1'b0);
        grant_ready = 1'b1;
        tick(); check_rr("idle2", 4'b0000, 2'd0, 1'b0);
        grant_ready = 1'b0;
        requests    = 4'b1111;
        tick(); check_rr("idle_resume", 4'b0100, 2'd2, 1'b1);

        // Async reset in the middle of a held grant
        tick(); check_rr("pre_reset_hold", 4'b0100, 2'd2, 1'b1);
        #2 reset = 1'b1;
        #1 check_rr("async_reset", 4'b0000, 2'd0, 1'b0);
        #1 reset = 1'b0;
        grant_ready = 1'b1;
        tick(); check_rr("post_reset", 4'b0001, 2'd0, 1'b1);
        tick(); check_rr("post_reset2", 4'b0010, 2'd1, 1'b1);

        // Fixed priority: index 1 always beats index 3
        f_requests    = 4'b1010;
        f_grant_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); check_fixed($sformatf("fixed%0d", i), 4'b0010, 2'd1, 1'b1);
        end
        f_requests = 4'b1000;
        tick(); check_fixed("fixed_only3", 4'b1000, 2'd3, 1'b1);

        // Single requester
        w_grant_ready = 1'b1;
        w_requests    = 1'b1;
        tick(); check_w1("w1_req", 1'b1, 1'b1);
        tick(); check_w1("w1_again", 1'b1, 1'b1);
        w_requests = 1'b0;
        tick(); check_w1("w1_drop", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
